// File: rtl/cond_exec_scheduler_if.sv
// Issue-port bundle for cond_exec_scheduler: decode handshake, flag
// write-back, flush, registered issue result and scoreboard status.
interface cond_exec_scheduler_if #(
   parameter int CNT_W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_cond;
   logic             in_set_flags;
   logic             flag_wr_en;
   logic [3:0]       flag_wr_data;
   logic             flush;
   logic             out_valid;
   logic             out_exec;
   logic             out_set_flags;
   logic [3:0]       status_q;
   logic             stall;
   logic [CNT_W-1:0] pending_cnt;
   logic             err_underflow;

   // Decode / EX side
   modport master (
      output in_valid, in_cond, in_set_flags, flag_wr_en, flag_wr_data, flush,
      input  in_ready, out_valid, out_exec, out_set_flags, status_q, stall,
             pending_cnt, err_underflow
   );

   // Scheduler side
   modport slave (
      input  in_valid, in_cond, in_set_flags, flag_wr_en, flag_wr_data, flush,
      output in_ready, out_valid, out_exec, out_set_flags, status_q, stall,
             pending_cnt, err_underflow
   );
endinterface

// File: rtl/cond_exec_scheduler.sv
// cond_exec_scheduler: owns NZCV ({z,c,n,v}), counts in-flight flag writers,
// stalls flag-dependent instructions and registers the condition decision.
// Optional macro FLAG_FORWARD_EN: a dependent instruction may issue in the
// cycle the last pending flag write-back arrives, evaluating flag_wr_data.
module cond_exec_scheduler #(
   parameter int MAX_PENDING = 3,
   parameter int CNT_W       = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   cond_exec_scheduler_if.slave  bus
);

   typedef enum logic [1:0] {RUN, BUSY, STALL} state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] pending_q, pending_d;
   logic [3:0]       status_q;
   logic             err_q;
   logic             out_valid_q, out_exec_q, out_set_q;

   logic             uses_flags, cnt_zero, cnt_full, fwd, dep_block;
   logic             ready, issue, exec_res, set_res, inc, dec;
   logic [3:0]       eval_flags;

   // ARM condition evaluation on flags ordered {z,c,n,v}
   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
      logic z, c, n, v;
      z = f[3];
      c = f[2];
      n = f[1];
      v = f[0];
      case (cond)
         4'h0:    return z;
         4'h1:    return ~z;
         4'h2:    return c;
         4'h3:    return ~c;
         4'h4:    return n;
         4'h5:    return ~n;
         4'h6:    return v;
         4'h7:    return ~v;
         4'h8:    return c & ~z;
         4'h9:    return ~c | z;
         4'hA:    return n == v;
         4'hB:    return n != v;
         4'hC:    return ~z & (n == v);
         4'hD:    return z | (n != v);
         4'hE:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Readiness, issue decision and scoreboard next count
   always_comb begin
      uses_flags = (bus.in_cond[3:1] != 3'b111);
      cnt_zero   = (pending_q == '0);
      cnt_full   = (pending_q == MAX_CNT);
`ifdef FLAG_FORWARD_EN
      fwd        = bus.flag_wr_en & (pending_q == CNT_W'(1));
`else
      fwd        = 1'b0;
`endif
      dep_block  = uses_flags & ~cnt_zero & ~fwd;
      eval_flags = fwd ? bus.flag_wr_data : status_q;
      ready      = ~bus.flush & ~dep_block & ~(bus.in_set_flags & cnt_full);
      issue      = bus.in_valid & ready;
      exec_res   = cond_eval(bus.in_cond, eval_flags);
      set_res    = bus.in_set_flags & exec_res;
      inc        = issue & set_res;
      dec        = bus.flag_wr_en & ~cnt_zero;
      pending_d  = pending_q;
      if (bus.flush)
         pending_d = '0;
      else if (inc & ~dec)
         pending_d = pending_q + CNT_W'(1);
      else if (dec & ~inc)
         pending_d = pending_q - CNT_W'(1);
   end

   // Scheduler state: flush wins, then a blocked instruction, then count
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (bus.flush)                     state_d = RUN;
            else if (bus.in_valid & ~ready)    state_d = STALL;
            else if (inc)                      state_d = BUSY;
            else                               state_d = RUN;
         end
         BUSY, STALL: begin
            if (bus.flush)                     state_d = RUN;
            else if (bus.in_valid & ~ready)    state_d = STALL;
            else if (pending_d == '0)          state_d = RUN;
            else                               state_d = BUSY;
         end
         default: state_d = RUN;
      endcase
   end

   // State, flags, scoreboard and registered issue result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         pending_q   <= '0;
         status_q    <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_exec_q  <= 1'b0;
         out_set_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         out_valid_q <= issue;
         if (bus.flag_wr_en)
            status_q <= bus.flag_wr_data;
         if (bus.flag_wr_en & cnt_zero)
            err_q <= 1'b1;
         if (issue) begin
            out_exec_q <= exec_res;
            out_set_q  <= set_res;
         end
      end
   end

   assign bus.in_ready      = ready;
   assign bus.stall         = bus.in_valid & ~ready;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_exec      = out_exec_q;
   assign bus.out_set_flags = out_set_q;
   assign bus.status_q      = status_q;
   assign bus.pending_cnt   = pending_q;
   assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_cond_exec_scheduler.sv
// Scoreboard bench for cond_exec_scheduler: directed scenarios followed by
// random traffic, checked against a behavioural model of the scheduler.
module tb_cond_exec_scheduler;

   localparam int MAX = 3;
`ifdef FLAG_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cond_exec_scheduler_if #(.CNT_W(3)) bus ();

   cond_exec_scheduler #(.MAX_PENDING(MAX), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   // expected {exec, set_flags} per issued instruction
   bit [1:0] q[$];

   // model state
   int       m_pending;
   bit [3:0] m_flags;
   bit       m_err;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ARM semantics: odd codes negate their even partner; 111x is AL/NV
   function automatic bit model_cond(input int cond, input bit [3:0] f);
      bit z, c, n, v, base;
      z = f[3]; c = f[2]; n = f[1]; v = f[0];
      case (cond / 2)
         0: base = z;
         1: base = c;
         2: base = n;
         3: base = v;
         4: base = c && !z;
         5: base = (n == v);
         6: base = !z && (n == v);
         default: return (cond == 14);
      endcase
      return (cond % 2 == 1) ? !base : base;
   endfunction

   task automatic model_reset();
      m_pending = 0;
      m_flags   = 4'b0;
      m_err     = 1'b0;
   endtask

   // One clock cycle: drive, check handshake, predict, advance, check state
   task automatic cyc(input bit v, input int cond, input bit sf,
                      input bit wr, input bit [3:0] wd, input bit fl);
      bit fwd, uses, rdy, e;
      int old;
      bus.in_valid     = v;
      bus.in_cond      = 4'(cond);
      bus.in_set_flags = sf;
      bus.flag_wr_en   = wr;
      bus.flag_wr_data = wd;
      bus.flush        = fl;
      #1;
      fwd  = FWD && m_pending == 1 && wr;
      uses = cond < 14;
      rdy  = !fl && !(uses && m_pending != 0 && !fwd) && !(sf && m_pending == MAX);
      chk("in_ready", bus.in_ready, rdy);
      chk("stall", bus.stall, v && !rdy);
      e = model_cond(cond, fwd ? wd : m_flags);
      if (v && rdy) q.push_back({e, sf && e});
      old = m_pending;
      if (wr && old == 0) m_err = 1'b1;
      if (fl) m_pending = 0;
      else begin
         if (v && rdy && sf && e) m_pending++;
         if (wr && old > 0) m_pending--;
      end
      if (wr) m_flags = wd;
      @(posedge clk);
      #1;
      chk("pending_cnt", bus.pending_cnt, m_pending);
      chk("status_q", bus.status_q, m_flags);
      chk("err_underflow", bus.err_underflow, m_err);
   endtask

   task automatic idle();
      cyc(0, 14, 0, 0, 4'b0, 0);
   endtask

   // Monitor: pop on every issue pulse, otherwise results must hold
   bit hold_e = 1'b0, hold_s = 1'b0;
   always @(negedge clk) begin
      bit [1:0] ex;
      if (rst) begin
         hold_e = 1'b0;
         hold_s = 1'b0;
      end
      if (bus.out_valid === 1'b1) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL out_valid: got 1 expected 0 (no issue pending) at %0t", $time);
         end else begin
            ex = q.pop_front();
            chk("out_exec", bus.out_exec, ex[1]);
            chk("out_set_flags", bus.out_set_flags, ex[0]);
            hold_e = ex[1];
            hold_s = ex[0];
         end
      end else begin
         chk("out_exec_hold", bus.out_exec, hold_e);
         chk("out_set_flags_hold", bus.out_set_flags, hold_s);
      end
   end

   initial begin
      rst = 1'b0;
      bus.in_valid = 0; bus.in_cond = 4'hE; bus.in_set_flags = 0;
      bus.flag_wr_en = 0; bus.flag_wr_data = 0; bus.flush = 0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_exec", bus.out_exec, 0);
      chk("rst_out_set_flags", bus.out_set_flags, 0);
      chk("rst_status_q", bus.status_q, 0);
      chk("rst_pending_cnt", bus.pending_cnt, 0);
      chk("rst_err_underflow", bus.err_underflow, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      rst = 1'b0;
      model_reset();

      // EQ then NE with flags zero
      cyc(1, 0, 0, 0, 4'b0, 0);
      cyc(1, 1, 0, 0, 4'b0, 0);
      idle();

      // ADDS then BEQ waiting on the flag write-back (z=1)
      cyc(1, 14, 1, 0, 4'b0, 0);
      cyc(1, 0, 0, 0, 4'b0, 0);
      cyc(1, 0, 0, 0, 4'b0, 0);
      cyc(1, 0, 0, 1, 4'b1000, 0);
      cyc(1, 0, 0, 0, 4'b0, 0);
      idle();

      // Fill the scoreboard, block a fourth writer, free one slot
      cyc(1, 14, 1, 0, 4'b0, 0);
      cyc(1, 14, 1, 0, 4'b0, 0);
      cyc(1, 14, 1, 0, 4'b0, 0);
      cyc(1, 14, 1, 0, 4'b0, 0);
      cyc(1, 14, 1, 1, 4'b1000, 0);
      cyc(1, 14, 1, 0, 4'b0, 0);
      cyc(0, 14, 0, 1, 4'b1000, 0);
      cyc(0, 14, 0, 1, 4'b1000, 0);
      cyc(0, 14, 0, 1, 4'b1000, 0);
      idle();

      // MOVNES with z=1 is annulled and does not count
      cyc(1, 1, 1, 0, 4'b0, 0);
      idle();

      // Flush together with a write-back while a dependent waits
      cyc(1, 14, 1, 0, 4'b0, 0);
      cyc(1, 14, 1, 0, 4'b0, 0);
      cyc(1, 0, 0, 0, 4'b0, 0);
      cyc(1, 0, 0, 1, 4'b0110, 1);
      chk("flush_out_valid", bus.out_valid, 0);
      cyc(1, 0, 0, 0, 4'b0, 0);
      idle();

      // Underflow is sticky
      cyc(0, 14, 0, 1, 4'b0011, 0);
      idle();
      idle();

      // Async reset while a dependent is stalled
      cyc(1, 14, 1, 0, 4'b0, 0);
      cyc(1, 0, 0, 0, 4'b0, 0);
      #1 rst = 1'b1;
      #1;
      q.delete();
      chk("arst_out_valid", bus.out_valid, 0);
      chk("arst_out_exec", bus.out_exec, 0);
      chk("arst_out_set_flags", bus.out_set_flags, 0);
      chk("arst_status_q", bus.status_q, 0);
      chk("arst_pending_cnt", bus.pending_cnt, 0);
      chk("arst_err_underflow", bus.err_underflow, 0);
      chk("arst_stall", bus.stall, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      idle();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom % 4) != 0, int'($urandom % 16), ($urandom % 2) == 1,
             (m_pending > 0) && (($urandom % 3) == 0), 4'($urandom),
             ($urandom % 20) == 0);
      end
      idle();
      idle();
      chk("queue_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cond_exec_scheduler.md
Name: cond_exec_scheduler

Overview:
Issue-stage controller that owns the architectural NZCV status register and decides when a conditional instruction may issue. It tracks in-flight flag-setting instructions with a scoreboard counter and stalls flag-dependent instructions until their flags are written back. At issue it evaluates the ARM condition code against the current flags, producing a registered execute/annul decision for the downstream EX stage.

Parameters:
MAX_PENDING, 3, maximum in-flight flag-setting instructions (1..7)
CNT_W, 3, scoreboard counter width; must hold MAX_PENDING

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  scheduler accepts it this cycle (combinational)
in_cond  in  4  condition field, ARM encoding 0000 EQ .. 1110 AL, 1111 NV
in_set_flags  in  1  instruction S bit
flag_wr_en  in  1  EX writes back new flags this cycle
flag_wr_data  in  4  new flags, order {z,c,n,v}
flush  in  1  pipeline flush (branch taken / exception)
out_valid  out  1  registered issue pulse
out_exec  out  1  registered condition result for the issued instruction
out_set_flags  out  1  registered: issued instruction will write flags
status_q  out  4  architectural flags {z,c,n,v}
stall  out  1  in_valid & ~in_ready
pending_cnt  out  CNT_W  in-flight flag writers
err_underflow  out  1  sticky: flag_wr_en seen with pending_cnt==0

Behaviour:
- Reset (async, rst=1): status_q=0, pending_cnt=0, out_valid=0, out_exec=0, out_set_flags=0, err_underflow=0, state=RUN. Reset mid-stall drops the held instruction; decode must re-present it.
- uses_flags = in_cond not in {1110, 1111}.
- in_ready = ~flush & ~(uses_flags & pending_cnt!=0) & ~(in_set_flags & pending_cnt==MAX_PENDING).
- Issue = in_valid & in_ready. Next cycle: out_valid=1; out_exec = eval(in_cond, status_q at the issue cycle); out_set_flags = in_set_flags & eval result. When no issue occurs, out_valid=0 and out_exec/out_set_flags hold their previous values.
- eval table: EQ z; NE ~z; CS c; CC ~c; MI n; PL ~n; VS v; VC ~v; HI c&~z; LS ~c|z; GE n==v; LT n!=v; GT ~z&(n==v); LE z|(n!=v); AL 1; NV 0.
- pending_cnt: +1 on an issue whose out_set_flags will be 1; -1 on flag_wr_en when pending_cnt>0. If both occur in the same cycle, the count is unchanged. flag_wr_en with pending_cnt==0 leaves the count at 0 and sets err_underflow (cleared only by rst).
- status_q <= flag_wr_data on any flag_wr_en, including during flush and during underflow.
- flush: in_ready=0 that cycle; pending_cnt <= 0 next cycle (any flag_wr_en in the same cycle is ignored for counting); out_valid=0 next cycle.
- Zero-latency scoreboard: an instruction stalled in cycle t can issue in cycle t+1 after the final flag_wr_en in cycle t, and it sees the updated status_q.
- FSM (observable via stall/pending_cnt):
  - RUN: pending_cnt==0.
  - BUSY: pending_cnt>0, no dependent instruction waiting.
  - STALL: in_valid & ~in_ready.
  - RUN->BUSY on a flag-setting issue. BUSY->RUN when the count reaches 0. Any state->STALL when a dependent instruction is blocked. STALL->RUN/BUSY on issue. Any state->RUN on flush.

Optional Feature:
FLAG_FORWARD_EN. When defined:
- A dependent instruction with pending_cnt==1 and flag_wr_en=1 (no flush) is ready in the same cycle.
- That instruction evaluates against flag_wr_data instead of status_q.
- The counter nets per the normal rules.
When undefined: the instruction waits one cycle, per the zero-latency scoreboard rule.

Test Plan:
1. Reset, status_q=0. Issue EQ (0000) -> out_valid=1 next cycle with out_exec=0. Issue NE -> out_exec=1.
2. Issue ADDS (cond AL, S=1) -> pending_cnt=1. Then present BEQ: stall=1 until flag_wr_en with data 4'b1000. The next cycle it issues with out_exec=1 and pending_cnt=0. With FLAG_FORWARD_EN it issues in the flag_wr_en cycle itself.
3. Issue three AL S=1 instructions back to back -> pending_cnt=3. A fourth S=1 has in_ready=0. flag_wr_en -> it issues next cycle and pending_cnt stays 3.
4. MOVNES with z=1 (out_exec=0) -> out_set_flags=0 and pending_cnt stays 0.
5. pending_cnt=2 and a dependent instruction stalled. Assert flush together with flag_wr_en, data 4'b0110 -> pending_cnt=0, status_q=0110, out_valid=0. The instruction issues the following cycle.
6. flag_wr_en with pending_cnt=0 -> err_underflow=1 and stays 1. Assert rst mid-stall -> all outputs return to their reset values asynchronously.
